// File: rtl/mdu_hilo_if.sv
// Request/result bundle between the EX stage and mdu_hilo.
// master = pipeline side (drives the request), slave = the MDU.
interface mdu_hilo_if #(parameter int WIDTH = 32);
  logic             start;
  logic [3:0]       MDUop;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic [WIDTH-1:0] HI;
  logic [WIDTH-1:0] LO;

  modport master (output start, MDUop, A, B, input busy, HI, LO);
  modport slave  (input start, MDUop, A, B, output busy, HI, LO);
endinterface

// File: rtl/mdu_hilo.sv
// Multi-cycle multiply/divide unit with HI/LO registers and fixed latency.
// Define MDU_MADD_EN to add madd/maddu accumulate ops.
module mdu_hilo #(
  parameter int WIDTH    = 32,
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10
) (
  input logic        clk,
  input logic        reset,
  mdu_hilo_if.slave  bus
);
  localparam int MAXL = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
  localparam int CW   = $clog2(MAXL + 1);
  localparam logic [CW-1:0] MULT_CNT = CW'(MULT_LAT);
  localparam logic [CW-1:0] DIV_CNT  = CW'(DIV_LAT);
  localparam logic [CW-1:0] ONE_CNT  = CW'(1);

  localparam logic [3:0] OP_MULT  = 4'b0001;
  localparam logic [3:0] OP_MULTU = 4'b0010;
  localparam logic [3:0] OP_DIV   = 4'b0011;
  localparam logic [3:0] OP_DIVU  = 4'b0100;
  localparam logic [3:0] OP_MTHI  = 4'b0101;
  localparam logic [3:0] OP_MTLO  = 4'b0110;
  localparam logic [3:0] OP_MADD  = 4'b0111;
  localparam logic [3:0] OP_MADDU = 4'b1000;

  typedef enum logic {IDLE, RUN} state_e;

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [3:0]         op_q, op_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               busy_q, busy_d;

  logic               is_mul_req, is_div_req;
  logic [2*WIDTH-1:0] prod_s, prod_u, res;
  logic [WIDTH-1:0]   b_safe, a_mag, b_mag, q_mag, r_mag;
  logic [WIDTH-1:0]   quo_s, rem_s, quo_u, rem_u;
  logic               a_neg, b_neg, b_zero;

  always_comb begin
    is_mul_req = (bus.MDUop == OP_MULT) || (bus.MDUop == OP_MULTU);
`ifdef MDU_MADD_EN
    is_mul_req = is_mul_req || (bus.MDUop == OP_MADD) || (bus.MDUop == OP_MADDU);
`endif
    is_div_req = (bus.MDUop == OP_DIV) || (bus.MDUop == OP_DIVU);
  end

  // Full-width products from the latched operands.
  always_comb begin
    prod_s = $signed({{WIDTH{a_q[WIDTH-1]}}, a_q}) * $signed({{WIDTH{b_q[WIDTH-1]}}, b_q});
    prod_u = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};
  end

  // Signed divide via magnitudes; most-negative / -1 falls out as LO=A, HI=0.
  always_comb begin
    b_zero = (b_q == '0);
    b_safe = b_zero ? WIDTH'(1) : b_q;
    a_neg  = a_q[WIDTH-1];
    b_neg  = b_q[WIDTH-1];
    a_mag  = a_neg ? (~a_q + WIDTH'(1)) : a_q;
    b_mag  = b_neg ? (~b_q + WIDTH'(1)) : b_safe;
    q_mag  = a_mag / b_mag;
    r_mag  = a_mag % b_mag;
    quo_s  = (a_neg ^ b_neg) ? (~q_mag + WIDTH'(1)) : q_mag;
    rem_s  = a_neg ? (~r_mag + WIDTH'(1)) : r_mag;
    quo_u  = a_q / b_safe;
    rem_u  = a_q % b_safe;
    if (b_zero) begin
      quo_s = '1; rem_s = a_q;
      quo_u = '1; rem_u = a_q;
    end
  end

  always_comb begin
    res = {hi_q, lo_q};
    case (op_q)
      OP_MULT:  res = prod_s;
      OP_MULTU: res = prod_u;
      OP_DIV:   res = {rem_s, quo_s};
      OP_DIVU:  res = {rem_u, quo_u};
`ifdef MDU_MADD_EN
      OP_MADD:  res = {hi_q, lo_q} + prod_s;
      OP_MADDU: res = {hi_q, lo_q} + prod_u;
`endif
      default:  res = {hi_q, lo_q};
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    busy_d  = busy_q;
    case (state_q)
      IDLE: if (bus.start) begin
        if (bus.MDUop == OP_MTHI) hi_d = bus.A;
        else if (bus.MDUop == OP_MTLO) lo_d = bus.A;
        else if (is_mul_req || is_div_req) begin
          op_d    = bus.MDUop;
          a_d     = bus.A;
          b_d     = bus.B;
          cnt_d   = is_mul_req ? MULT_CNT : DIV_CNT;
          state_d = RUN;
          busy_d  = 1'b1;
        end
      end
      RUN: begin
        cnt_d = cnt_q - ONE_CNT;
        if (cnt_q == ONE_CNT) begin
          {hi_d, lo_d} = res;
          state_d      = IDLE;
          busy_d       = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.HI   = hi_q;
  assign bus.LO   = lo_q;
endmodule

// File: tb/tb_mdu_hilo.sv
// Directed vector bench for mdu_hilo: op table plus hand-written corner sequences.
module tb_mdu_hilo;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;

  mdu_hilo_if #(.WIDTH(32)) bus ();
  mdu_hilo #(.WIDTH(32), .MULT_LAT(5), .DIV_LAT(10)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    int          exp_lat;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge where busy is low again.
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int lat);
    bus.start = 1'b1; bus.MDUop = op; bus.A = a; bus.B = b;
    @(negedge clk);
    bus.start = 1'b0;
    lat = 0;
    while (bus.busy && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  vec_t vecs[$];
  int   n;

  initial begin
    vecs.push_back('{"mult_neg",   4'b0001, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFE, 5});
    vecs.push_back('{"multu",      4'b0010, 32'hFFFFFFFF, 32'd2,        32'h00000001, 32'hFFFFFFFE, 5});
    vecs.push_back('{"div_m7_2",   4'b0011, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 10});
    vecs.push_back('{"divu_by0",   4'b0100, 32'd7,        32'd0,        32'h00000007, 32'hFFFFFFFF, 10});
    vecs.push_back('{"div_ovf",    4'b0011, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10});
    vecs.push_back('{"div_by0",    4'b0011, 32'd7,        32'd0,        32'h00000007, 32'hFFFFFFFF, 10});
    vecs.push_back('{"divu_100_7", 4'b0100, 32'd100,      32'd7,        32'h00000002, 32'h0000000E, 10});
    vecs.push_back('{"div_7_m2",   4'b0011, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 10});
    vecs.push_back('{"mult_2p32",  4'b0001, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 5});
    vecs.push_back('{"mthi0",      4'b0101, 32'h0,        32'h0,        32'h00000000, 32'h00000000, 0});
    vecs.push_back('{"mtlo1s",     4'b0110, 32'hFFFFFFFF, 32'h0,        32'h00000000, 32'hFFFFFFFF, 0});
`ifdef MDU_MADD_EN
    vecs.push_back('{"maddu",      4'b1000, 32'd1,        32'd1,        32'h00000001, 32'h00000000, 5});
    vecs.push_back('{"madd_neg",   4'b0111, 32'hFFFFFFFF, 32'd1,        32'h00000000, 32'hFFFFFFFF, 5});
`else
    vecs.push_back('{"maddu_nop",  4'b1000, 32'd1,        32'd1,        32'h00000000, 32'hFFFFFFFF, 0});
    vecs.push_back('{"madd_nop",   4'b0111, 32'hFFFFFFFF, 32'd1,        32'h00000000, 32'hFFFFFFFF, 0});
`endif
    vecs.push_back('{"nop",        4'b0000, 32'h5,        32'h5,        32'h00000000, 32'hFFFFFFFF, 0});
    vecs.push_back('{"nop_hi",     4'b1111, 32'h5,        32'h5,        32'h00000000, 32'hFFFFFFFF, 0});

    reset = 1'b1; bus.start = 1'b0; bus.MDUop = '0; bus.A = '0; bus.B = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("reset_hi", {32'h0, bus.HI}, 64'h0);
    check("reset_lo", {32'h0, bus.LO}, 64'h0);
    check("reset_busy", {63'h0, bus.busy}, 64'h0);

    // Vectors run back to back with zero gap between ops.
    foreach (vecs[i]) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, n);
      check({vecs[i].name, "_lat"}, 64'(n), 64'(vecs[i].exp_lat));
      check({vecs[i].name, "_hi"}, {32'h0, bus.HI}, {32'h0, vecs[i].exp_hi});
      check({vecs[i].name, "_lo"}, {32'h0, bus.LO}, {32'h0, vecs[i].exp_lo});
    end

    // mthi then mtlo on consecutive cycles.
    bus.start = 1'b1; bus.MDUop = 4'b0101; bus.A = 32'h12345678;
    @(negedge clk);
    check("mthi_next", {32'h0, bus.HI}, 64'h12345678);
    check("mthi_busy", {63'h0, bus.busy}, 64'h0);
    bus.MDUop = 4'b0110; bus.A = 32'h9ABCDEF0;
    @(negedge clk);
    bus.start = 1'b0;
    check("mtlo_next", {32'h0, bus.LO}, 64'h9ABCDEF0);
    check("mtlo_hi_kept", {32'h0, bus.HI}, 64'h12345678);
    check("mtlo_busy", {63'h0, bus.busy}, 64'h0);

    // Request during busy is ignored; operands were latched at accept.
    bus.start = 1'b1; bus.MDUop = 4'b0001; bus.A = 32'd3; bus.B = 32'd5;
    @(negedge clk);
    bus.start = 1'b0;
    n = 0;
    while (bus.busy && n < 40) begin
      if (n == 1) begin
        bus.start = 1'b1; bus.MDUop = 4'b0011; bus.A = 32'd100; bus.B = 32'd7;
      end else begin
        bus.start = 1'b0;
      end
      if (n < 4) check("ign_hold_lo", {32'h0, bus.LO}, 64'h9ABCDEF0);
      @(negedge clk);
      n++;
    end
    bus.start = 1'b0;
    check("ign_lat", 64'(n), 64'd5);
    check("ign_hi", {32'h0, bus.HI}, 64'h0);
    check("ign_lo", {32'h0, bus.LO}, 64'd15);
    @(negedge clk);
    check("ign_no_restart", {63'h0, bus.busy}, 64'h0);

    // Reset mid-divide aborts without a later commit.
    bus.start = 1'b1; bus.MDUop = 4'b0011; bus.A = 32'd100; bus.B = 32'd7;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_mid_busy_before", {63'h0, bus.busy}, 64'h1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rst_mid_hi", {32'h0, bus.HI}, 64'h0);
    check("rst_mid_lo", {32'h0, bus.LO}, 64'h0);
    check("rst_mid_busy", {63'h0, bus.busy}, 64'h0);
    repeat (15) @(negedge clk);
    check("rst_no_commit_lo", {32'h0, bus.LO}, 64'h0);
    check("rst_no_commit_hi", {32'h0, bus.HI}, 64'h0);

    // Reset and start together: reset wins.
    reset = 1'b1; bus.start = 1'b1; bus.MDUop = 4'b0101; bus.A = 32'h5;
    @(negedge clk);
    reset = 1'b0; bus.start = 1'b0;
    check("rst_start_hi", {32'h0, bus.HI}, 64'h0);
    @(negedge clk);
    check("rst_start_busy", {63'h0, bus.busy}, 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mdu_hilo.md
# mdu_hilo

Parametrised multi-cycle multiply/divide unit with HI/LO registers. It sits beside the ALU in the EX stage and executes mult, multu, div, divu, mthi and mtlo. Multi-cycle operations run with a fixed, configurable latency and raise `busy` while they run; the pipeline stalls on `busy`. HI/LO are architectural outputs read by mfhi/mflo.

## Interface

Parameters:
- WIDTH, 32, operand and HI/LO width
- MULT_LAT, 5, cycles from accept to result for multiply ops (>= 1)
- DIV_LAT, 10, cycles from accept to result for divide ops (>= 1)

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous active-high reset
- start  in  1  request; MDUop/A/B valid this cycle
- MDUop  in  4  operation code (below)
- A  in  WIDTH  rs operand / dividend
- B  in  WIDTH  rt operand / divisor
- busy  out  1  multi-cycle operation in flight
- HI  out  WIDTH  HI register
- LO  out  WIDTH  LO register

## Operation

- MDUop: 0000 nop, 0001 mult, 0010 multu, 0011 div, 0100 divu, 0101 mthi, 0110 mtlo, 0111 madd, 1000 maddu; other codes are nop.
- Accept: `start`=1, `busy`=0, op not nop, at a rising edge. `start` while `busy`=1 is ignored entirely (pipeline guarantees it never issues one).
- mthi/mtlo: HI<=A or LO<=A at the accept edge; `busy` stays 0.
- mult/multu: {HI,LO} <= A*B, signed/unsigned, full 2*WIDTH product.
- div/divu: LO <= quotient, HI <= remainder; signed quotient truncates toward zero, remainder takes sign of dividend.
- Divide by zero (B=0): HI <= A, LO <= all ones, both signed and unsigned.
- Signed overflow (A = most negative, B = -1): LO <= A, HI <= 0.
- Operands and op are latched at accept; A/B/MDUop changes afterwards have no effect.
- State: IDLE -> RUN on multi-cycle accept (counter loaded with MULT_LAT or DIV_LAT); RUN decrements each edge; at count 1 -> commit result, return to IDLE.

## Timing

- Reset values: HI=0, LO=0, busy=0, counter=0, state IDLE.
- Multi-cycle op accepted at edge E0: `busy`=1 from E0 to E_LAT; at edge E_LAT HI/LO take the result and `busy` returns to 0 in the same edge. `busy` is high for exactly LAT cycles.
- HI/LO hold old values throughout RUN; no partial results are visible.
- New op may be accepted on the cycle `busy` is 0 again (back-to-back, zero gap).
- mthi/mtlo: result visible the cycle after the accept edge.
- Reset mid-operation: aborts, no commit, HI/LO=0, busy=0 after the edge. Reset and start in the same cycle: reset wins, request dropped.
- `busy` is registered; the decode stage ORs it with (start & multi-cycle op) to form its stall.

## Configuration

- MDU_MADD_EN defined: madd (0111) and maddu (1000) supported, {HI,LO} <= {HI,LO} + A*B (signed/unsigned product, modulo 2^(2*WIDTH)), latency MULT_LAT; the {HI,LO} used is the value at the commit edge.
- Not defined: 0111 and 1000 are nop; no accumulator adder is built.

## Test plan

- Reset, then mult A=0xFFFFFFFF B=2 -> busy high exactly 5 cycles, then HI=0xFFFFFFFF LO=0xFFFFFFFE; multu same operands -> HI=0x00000001 LO=0xFFFFFFFE.
- div A=-7 B=2 -> after 10 cycles LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1); divu A=7 B=0 -> HI=7 LO=0xFFFFFFFF; div A=0x80000000 B=-1 -> LO=0x80000000 HI=0.
- mthi A=0x12345678 then mtlo A=0x9ABCDEF0 on consecutive cycles -> HI/LO updated next cycle each, busy never asserted.
- Start mult, change A/B and assert start with div on cycle 2 -> second request ignored, result is the original product, busy drops after 5 cycles.
- Start div, assert reset on cycle 4 -> HI=LO=0, busy=0 next cycle, no later commit.
- With MDU_MADD_EN: HI=0 LO=0xFFFFFFFF, maddu A=1 B=1 -> HI=1 LO=0; without macro same stimulus -> no change, busy stays 0.
